// File: rtl/wb_lsu_master_pkg.sv
// Shared constants and types for the Wishbone load/store master.
// Holds the access size encodings and the FSM state encoding.
package wb_lsu_master_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUS  = 2'b01,
    LSU_RESP = 2'b10
  } lsu_state_e;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational lane handling: byte selects, store replication, load shift/extend
// and the alignment check for one access.
module wb_lane_align
  import wb_lsu_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] dat_out,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    sel        = 4'b0000;
    dat_out    = wdata;
    misaligned = 1'b0;
    shifted    = bus_rdata >> {addr_lo, 3'b000};
    load_data  = shifted;
    case (size)
      LSU_SIZE_B: begin
        sel       = 4'b0001 << addr_lo;
        dat_out   = {4{wdata[7:0]}};
        load_data = is_unsigned ? {24'h000000, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      LSU_SIZE_H: begin
        sel        = 4'b0011 << addr_lo;
        dat_out    = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        load_data  = is_unsigned ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      LSU_SIZE_W: begin
        sel        = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic initiator for the data port: one load/store request
// becomes one bus cycle, with alignment faults, bus errors and timeouts reported.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        rsp_misaligned,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

  lsu_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        size_reg, size_next;
  logic [1:0]        addr_lo_reg, addr_lo_next;
  logic              uns_reg, uns_next;
  logic              cyc_reg, cyc_next;
  logic [31:0]       adr_reg, adr_next;
  logic              we_reg, we_next;
  logic [3:0]        sel_reg, sel_next;
  logic [31:0]       dat_reg, dat_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_tmo_reg, rsp_tmo_next;
  logic              rsp_mis_reg, rsp_mis_next;

  logic              idle;
  logic [1:0]        align_size;
  logic [1:0]        align_addr_lo;
  logic              align_uns;
  logic [3:0]        align_sel;
  logic [31:0]       align_dat;
  logic [31:0]       align_load;
  logic              align_mis;

  // While idle the aligner looks at the incoming request; afterwards it
  // works from the latched request so the ack-edge extraction is stable.
  assign idle          = (state_reg == LSU_IDLE);
  assign align_size    = idle ? req_size       : size_reg;
  assign align_addr_lo = idle ? req_addr[1:0]  : addr_lo_reg;
  assign align_uns     = idle ? req_unsigned   : uns_reg;

  wb_lane_align u_align (
    .size        (align_size),
    .addr_lo     (align_addr_lo),
    .is_unsigned (align_uns),
    .wdata       (req_wdata),
    .bus_rdata   (wb_dat_i),
    .sel         (align_sel),
    .dat_out     (align_dat),
    .load_data   (align_load),
    .misaligned  (align_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LSU_IDLE;
      cnt_reg       <= '0;
      size_reg      <= 2'b00;
      addr_lo_reg   <= 2'b00;
      uns_reg       <= 1'b0;
      cyc_reg       <= 1'b0;
      adr_reg       <= '0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'b0000;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
      rsp_mis_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      size_reg      <= size_next;
      addr_lo_reg   <= addr_lo_next;
      uns_reg       <= uns_next;
      cyc_reg       <= cyc_next;
      adr_reg       <= adr_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_tmo_reg   <= rsp_tmo_next;
      rsp_mis_reg   <= rsp_mis_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    size_next      = size_reg;
    addr_lo_next   = addr_lo_reg;
    uns_next       = uns_reg;
    cyc_next       = cyc_reg;
    adr_next       = adr_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    dat_next       = dat_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_tmo_next   = rsp_tmo_reg;
    rsp_mis_next   = rsp_mis_reg;

    case (state_reg)
      LSU_IDLE: begin
        if (req_valid) begin
          size_next      = req_size;
          addr_lo_next   = req_addr[1:0];
          uns_next       = req_unsigned;
          cnt_next       = '0;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b0;
          rsp_tmo_next   = 1'b0;
          rsp_mis_next   = 1'b0;
          if (align_mis) begin
            state_next     = LSU_RESP;
            rsp_valid_next = 1'b1;
            rsp_mis_next   = 1'b1;
          end else begin
            state_next = LSU_BUS;
            cyc_next   = 1'b1;
            adr_next   = word_addr(req_addr);
            we_next    = req_we;
            sel_next   = align_sel;
            dat_next   = align_dat;
          end
        end
      end

      LSU_BUS: begin
        // Error wins over a simultaneous ack so a faulting store is never
        // reported as completed.
        if (wb_err_i) begin
          state_next     = LSU_RESP;
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end else if (wb_ack_i) begin
          state_next     = LSU_RESP;
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = we_reg ? 32'h0000_0000 : align_load;
        end else if (TMO_EN && (cnt_reg == TMO_LIMIT)) begin
          state_next     = LSU_RESP;
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_tmo_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      LSU_RESP: begin
        state_next     = LSU_IDLE;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;
        rsp_tmo_next   = 1'b0;
        rsp_mis_next   = 1'b0;
      end

      default: begin
        state_next = LSU_IDLE;
        cyc_next   = 1'b0;
      end
    endcase
  end

  assign req_ready      = idle;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_err        = rsp_err_reg;
  assign rsp_timeout    = rsp_tmo_reg;
  assign rsp_misaligned = rsp_mis_reg;
  assign wb_adr_o       = adr_reg;
  assign wb_dat_o       = dat_reg;
  assign wb_we_o        = we_reg;
  assign wb_sel_o       = sel_reg;
  assign wb_cyc_o       = cyc_reg;
  assign wb_stb_o       = cyc_reg;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a one-word Wishbone slave whose
// behaviour (registered ack, err+ack, silent) is selectable per step.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        rsp_misaligned;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  // slave model
  int          slave_mode;   // 0 = normal ack, 1 = err+ack, 2 = silent
  logic [31:0] mem_word;
  logic        bd_we;
  logic [31:0] bd_data;

  always #5 clk = ~clk;

  wb_lsu_master #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_timeout    (rsp_timeout),
    .rsp_misaligned (rsp_misaligned),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_we_o        (wb_we_o),
    .wb_sel_o       (wb_sel_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i)
  );

  always @(posedge clk) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= 32'h0;
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (bd_we) mem_word <= bd_data;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
        if (slave_mode == 0) begin
          wb_ack_i <= 1'b1;
          wb_dat_i <= mem_word;
          if (wb_we_o) begin
            for (int i = 0; i < 4; i++)
              if (wb_sel_o[i]) mem_word[8*i +: 8] <= wb_dat_o[8*i +: 8];
          end
        end else if (slave_mode == 1) begin
          wb_ack_i <= 1'b1;
          wb_err_i <= 1'b1;
          wb_dat_i <= 32'hCAFE_BABE;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // transaction results
  int          r_rsp_edge;
  int          r_drop_edge;
  logic        r_cyc_seen;
  logic        r_ready0;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [31:0] r_adr;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_tmo;
  logic        r_mis;
  logic        r_stb_at_rsp;

  // Called at a sample point (#1 after an edge) with the DUT idle.
  // Edge indices count from the accepting edge E0 = 0.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_ready0 = req_ready;
    r_sel = wb_sel_o; r_dat = wb_dat_o; r_adr = wb_adr_o; r_we = wb_we_o;
    r_cyc_seen = wb_cyc_o; r_drop_edge = -1; r_rsp_edge = -1;
    r_rdata = 'x; r_err = 1'bx; r_tmo = 1'bx; r_mis = 1'bx; r_stb_at_rsp = 1'bx;
    for (int k = 0; k < 40 && r_rsp_edge < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (wb_cyc_o) r_cyc_seen = 1'b1;
      else if (r_cyc_seen && r_drop_edge < 0) r_drop_edge = k;
      if (rsp_valid) begin
        r_rsp_edge = k; r_rdata = rsp_rdata; r_err = rsp_err;
        r_tmo = rsp_timeout; r_mis = rsp_misaligned; r_stb_at_rsp = wb_stb_o;
      end
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h rsp_edge=%0d rdata=%h err=%0d tmo=%0d mis=%0d",
             we, size, uns, addr, wdata, r_rsp_edge, r_rdata, r_err, r_tmo, r_mis);
    @(posedge clk); #1;
    check("rsp_single_pulse", {31'b0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic poke(input logic [31:0] d);
    bd_we = 1'b1; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  initial begin
    int rsp_seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    slave_mode = 0; bd_we = 1'b0; bd_data = 32'h0; mem_word = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_flags", {29'b0, rsp_err, rsp_timeout, rsp_misaligned}, 32'd0);
    check("rst_cyc_stb_we", {29'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("rst_sel", {28'b0, wb_sel_o}, 32'd0);
    check("rst_adr", wb_adr_o, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // store byte to lane 3
    poke(32'h1122_3344);
    do_txn(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    check("sb_ready_busy", {31'b0, r_ready0}, 32'd0);
    check("sb_sel", {28'b0, r_sel}, 32'h8);
    check("sb_dat", r_dat, 32'hA5A5_A5A5);
    check("sb_adr", r_adr, 32'h0000_1000);
    check("sb_we", {31'b0, r_we}, 32'd1);
    check("sb_rsp_edge", r_rsp_edge, 32'd2);
    check("sb_drop_edge", r_drop_edge, 32'd2);
    check("sb_stb_after_ack", {31'b0, r_stb_at_rsp}, 32'd0);
    check("sb_rdata", r_rdata, 32'd0);
    check("sb_err", {31'b0, r_err}, 32'd0);
    check("sb_mem", mem_word, 32'hA522_3344);

    // half loads, signed and unsigned
    poke(32'h8001_1234);
    do_txn(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0);
    check("lh_sel", {28'b0, r_sel}, 32'hC);
    check("lh_we", {31'b0, r_we}, 32'd0);
    check("lh_rdata", r_rdata, 32'hFFFF_8001);
    check("lh_rsp_edge", r_rsp_edge, 32'd2);
    do_txn(1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0);
    check("lhu_rdata", r_rdata, 32'h0000_8001);
    check("lhu_rsp_edge", r_rsp_edge, 32'd2);

    // byte loads from other lanes, word load ignoring unsigned
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    check("lb3_rdata", r_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0);
    check("lb1_sel", {28'b0, r_sel}, 32'h2);
    check("lb1_rdata", r_rdata, 32'h0000_0012);
    do_txn(1'b0, 2'b10, 1'b1, 32'h0000_1000, 32'h0);
    check("lw_sel", {28'b0, r_sel}, 32'hF);
    check("lw_rdata", r_rdata, 32'h8001_1234);

    // store half to upper lanes, then read the whole word back
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'hDEAD_BEEF);
    check("sh_sel", {28'b0, r_sel}, 32'hC);
    check("sh_dat", r_dat, 32'hBEEF_BEEF);
    check("sh_mem", mem_word, 32'hBEEF_1234);
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    check("lw2_rdata", r_rdata, 32'hBEEF_1234);

    // misaligned accesses never reach the bus
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1001, 32'h0);
    check("misw_rsp_edge", r_rsp_edge, 32'd0);
    check("misw_flag", {31'b0, r_mis}, 32'd1);
    check("misw_err", {31'b0, r_err}, 32'd0);
    check("misw_cyc", {31'b0, r_cyc_seen}, 32'd0);
    check("misw_rdata", r_rdata, 32'd0);
    do_txn(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h1234_5678);
    check("mish_flag", {31'b0, r_mis}, 32'd1);
    check("mish_cyc", {31'b0, r_cyc_seen}, 32'd0);
    check("mish_mem", mem_word, 32'hBEEF_1234);
    do_txn(1'b0, 2'b11, 1'b0, 32'h0000_1000, 32'h0);
    check("size3_flag", {31'b0, r_mis}, 32'd1);
    check("size3_cyc", {31'b0, r_cyc_seen}, 32'd0);

    // bus error together with ack
    slave_mode = 1;
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    check("berr_err", {31'b0, r_err}, 32'd1);
    check("berr_tmo", {31'b0, r_tmo}, 32'd0);
    check("berr_mis", {31'b0, r_mis}, 32'd0);
    check("berr_rdata", r_rdata, 32'd0);
    check("berr_rsp_edge", r_rsp_edge, 32'd2);

    // timeout with a silent slave
    slave_mode = 2;
    do_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    check("tmo_drop_edge", r_drop_edge, 32'd5);
    check("tmo_rsp_edge", r_rsp_edge, 32'd5);
    check("tmo_err", {31'b0, r_err}, 32'd1);
    check("tmo_flag", {31'b0, r_tmo}, 32'd1);
    check("tmo_rdata", r_rdata, 32'd0);

    // reset one cycle into the bus phase
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_1000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rstmid_cyc_up", {31'b0, wb_cyc_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    rst = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) rsp_seen++;
      @(posedge clk); #1;
    end
    $display("txn reset-abort rsp_pulses=%0d req_ready=%0d", rsp_seen, req_ready);
    check("rstmid_no_rsp", rsp_seen, 32'd0);
    check("rstmid_ready", {31'b0, req_ready}, 32'd1);

    // recovery after the abandoned transaction
    slave_mode = 0;
    do_txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    check("recov_rdata", r_rdata, 32'h0000_00BE);
    check("recov_rsp_edge", r_rsp_edge, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
